// File: rtl/stack_pkg.sv
// Shared constants and types for the stack evaluator datapath
// (operand_stack, stack controller, ALU).
package stack_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 5;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0]  operand_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array backing the operand stack.
// Ports:
//   clk     rising-edge clock
//   we      write enable
//   waddr   write address
//   wdata   write data
//   raddr   asynchronous read address (NOS refill)
//   rdata_c combinational read data
// Contents are not reset; the stack never reads an entry it has not written.
module stack_mem
  import stack_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  addr_t    waddr,
  input  operand_t wdata,
  input  addr_t    raddr,
  output operand_t rdata_c
);

  operand_t mem_q [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Asynchronous read port
  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/operand_stack.sv
// operand_stack: hardware LIFO of 16-bit operands with registered TOS/NOS.
// Ports:
//   clk, rst (async, active-low)
//   push, pop, din        operation strobes and push data
//   clr                   synchronous clear (only when STACK_CLEAR_EN is defined)
//   tos, nos              top / next-on-stack, zero when not present
//   pos                   entry count 0..DEPTH
//   empty, full           decoded from the registered count
//   ovf, unf              sticky overflow / underflow flags
// Configuration macro: STACK_CLEAR_EN adds the clr port.
// mem holds entries 0..pos-1; TOS and NOS are mirrored in registers so
// outputs never depend combinationally on push/pop.
module operand_stack
  import stack_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  operand_t din,
`ifdef STACK_CLEAR_EN
  input  logic     clr,
`endif
  output operand_t tos,
  output operand_t nos,
  output ptr_t     pos,
  output logic     empty,
  output logic     full,
  output logic     ovf,
  output logic     unf
);

  operand_t tos_q, tos_d;
  operand_t nos_q, nos_d;
  ptr_t     pos_q, pos_d;
  logic     empty_q, empty_d;
  logic     full_q, full_d;
  logic     ovf_q, ovf_d;
  logic     unf_q, unf_d;

  logic     mem_we_c;
  addr_t    mem_waddr_c;
  addr_t    mem_raddr_c;
  operand_t mem_rdata_c;
  logic     clr_c;

`ifdef STACK_CLEAR_EN
  assign clr_c = clr;
`else
  assign clr_c = 1'b0;
`endif

  // Entry that becomes NOS after a pop (mem[pos-3]); only used when pos>=3
  assign mem_raddr_c = ADDR_W'(pos_q - ptr_t'(3));

  stack_mem u_mem (
    .clk     (clk),
    .we      (mem_we_c),
    .waddr   (mem_waddr_c),
    .wdata   (din),
    .raddr   (mem_raddr_c),
    .rdata_c (mem_rdata_c)
  );

  // Op decode: clear > replace > push > pop
  always_comb begin
    tos_d       = tos_q;
    nos_d       = nos_q;
    pos_d       = pos_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = ADDR_W'(pos_q);

    if (clr_c) begin
      tos_d = '0;
      nos_d = '0;
      pos_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (push && pop && !empty_q) begin
      // Replace TOS in place; depth and NOS untouched
      tos_d       = din;
      mem_we_c    = 1'b1;
      mem_waddr_c = ADDR_W'(pos_q - ptr_t'(1));
    end else if (push) begin
      // Also covers push&pop on an empty stack
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        mem_we_c = 1'b1;
        tos_d    = din;
        nos_d    = tos_q;
        pos_d    = pos_q + ptr_t'(1);
      end
    end else if (pop) begin
      if (empty_q) begin
        unf_d = 1'b1;
      end else begin
        tos_d = nos_q;
        nos_d = (pos_q >= ptr_t'(3)) ? mem_rdata_c : '0;
        pos_d = pos_q - ptr_t'(1);
      end
    end

    empty_d = (pos_d == '0);
    full_d  = (pos_d == ptr_t'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q   <= '0;
      nos_q   <= '0;
      pos_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      pos_q   <= pos_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tos   = tos_q;
  assign nos   = nos_q;
  assign pos   = pos_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: a queue-based LIFO model predicts the
// state after every operation; a negedge monitor compares the DUT against it.
module tb_operand_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop;
  logic [15:0] din;
  logic        clr;
  logic [15:0] tos, nos;
  logic [4:0]  pos;
  logic        empty, full, ovf, unf;

  always #5 clk = ~clk;

  operand_stack dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
`ifdef STACK_CLEAR_EN
    .clr   (clr),
`endif
    .tos   (tos),
    .nos   (nos),
    .pos   (pos),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  typedef struct {
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  pos;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  localparam int CAP = 16;

  logic [15:0] stk[$];
  logic        m_ovf, m_unf;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_state();
    exp_t e;
    int   n = stk.size();
    e.tos   = (n >= 1) ? stk[n-1] : 16'h0;
    e.nos   = (n >= 2) ? stk[n-2] : 16'h0;
    e.pos   = 5'(n);
    e.empty = (n == 0);
    e.full  = (n == CAP);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_reset();
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic o, input logic [15:0] d, input logic c);
    if (c) model_reset();
    else if (p && o && stk.size() > 0) stk[stk.size()-1] = d;
    else if (p) begin
      if (stk.size() == CAP) m_ovf = 1'b1;
      else stk.push_back(d);
    end else if (o) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else void'(stk.pop_back());
    end
  endtask

  task automatic cmp_state(input string tag, input exp_t e);
    chk({tag, ".tos"},   32'(tos),   32'(e.tos));
    chk({tag, ".nos"},   32'(nos),   32'(e.nos));
    chk({tag, ".pos"},   32'(pos),   32'(e.pos));
    chk({tag, ".empty"}, 32'(empty), 32'(e.empty));
    chk({tag, ".full"},  32'(full),  32'(e.full));
    chk({tag, ".ovf"},   32'(ovf),   32'(e.ovf));
    chk({tag, ".unf"},   32'(unf),   32'(e.unf));
  endtask

  // Issue one op: inputs already at posedge+1, applied on the next edge
  task automatic do_op(input logic p, input logic o, input logic [15:0] d, input logic c);
    push = p;
    pop  = o;
    din  = d;
`ifdef STACK_CLEAR_EN
    clr  = c;
`else
    clr  = 1'b0;
`endif
    @(posedge clk);
    model_step(p, o, d, clr);
    sb.push_back(model_state());
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
  endtask

  // Monitor: one expected result per issued op
  always @(negedge clk) begin
    if (rst && sb.size() > 0) cmp_state("mon", sb.pop_front());
  end

  task automatic drain();
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    model_reset();
    cmp_state("reset", model_state());
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    push = 1'b0; pop = 1'b0; din = '0; clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #3;
    reset_pulse();

    // Basic pushes and pops down to empty
    do_op(1, 0, 16'h0001, 0);
    do_op(1, 0, 16'h0002, 0);
    do_op(1, 0, 16'h0003, 0);
    repeat (3) do_op(0, 1, 16'h0, 0);
    // Underflow is sticky through later pushes
    do_op(0, 1, 16'h0, 0);
    do_op(1, 0, 16'h1234, 0);
    do_op(0, 1, 16'h0, 0);
    drain();

    // Fill to capacity, then overflow
    reset_pulse();
    for (int i = 0; i < 16; i++) do_op(1, 0, 16'(16'h8000 + i), 0);
    do_op(1, 0, 16'hDEAD, 0);
    do_op(1, 1, 16'h7777, 0);
    drain();

    // Replace TOS at depth 2, then pop
    reset_pulse();
    do_op(1, 0, 16'h0055, 0);
    do_op(1, 0, 16'h00AA, 0);
    do_op(1, 1, 16'hFFFF, 0);
    do_op(0, 1, 16'h0, 0);
    // push&pop on empty acts as push
    do_op(0, 1, 16'h0, 0);
    do_op(1, 1, 16'h4242, 0);
    drain();

    // Asynchronous reset in the middle of a push burst
    reset_pulse();
    for (int i = 0; i < 5; i++) do_op(1, 0, 16'(16'h0100 + i), 0);
    drain();
    push = 1'b1;
    din  = 16'hBEEF;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    cmp_state("async_rst", model_state());
    @(posedge clk);
    #1;
    push = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    #1;

`ifdef STACK_CLEAR_EN
    do_op(0, 1, 16'h0, 0);
    for (int i = 0; i < 4; i++) do_op(1, 0, 16'(16'h0200 + i), 0);
    do_op(1, 0, 16'hCAFE, 1);
    do_op(1, 0, 16'h0300, 0);
    drain();
`endif

    // Randomized phases alternating push-heavy and pop-heavy traffic
    for (int ph = 0; ph < 8; ph++) begin
      int push_pct = (ph % 2 == 0) ? 75 : 25;
      for (int k = 0; k < 250; k++) begin
        int  r  = $urandom_range(0, 99);
        int  r2 = $urandom_range(0, 99);
        logic p = (r < push_pct);
        logic o = (r2 < 50) ? ~p : (r2 < 60);
        logic c = ($urandom_range(0, 99) < 2);
        do_op(p, o, 16'($urandom), c);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
